spi_slave_param: RTL and testbench
==================================

// Module: spi_slave_param
// PURPOSE
// - Parametrised SPI slave front-end. Replaces the fixed 10-bit/8-bit slave.
// - Frames MOSI bits into command+payload words (rx_data/rx_valid) for the RAM
//   controller, and serialises RAM read data (tx_data/tx_valid) onto MISO.
// - New over the fixed slave: configurable data width and bit order,
//   single-cycle rx_valid, explicit tx wait/shift states, aborted-frame flag,
//   busy output.
// PARAMETERS
// - DATA_W     8   payload width; rx word = DATA_W+2 (2-bit opcode + payload)
// - MSB_FIRST  1   1: rx/tx serialised MSB first; 0: LSB first
// PORTS
// - clk       in   1         system clock; all logic samples on rising edge
// - rst       in   1         asynchronous, active-high reset
// - ss_n      in   1         slave select, active low; frames one transaction
// - mosi      in   1         serial data in, sampled every clk while framed
// - miso      out  1         serial data out (registered)
// - rx_data   out  DATA_W+2  received word {opcode[1:0], payload}
// - rx_valid  out  1         one-cycle strobe: rx_data updated this cycle
// - tx_data   in   DATA_W    read data to send to master
// - tx_valid  in   1         tx_data valid; consumed only in TX_WAIT
// - busy      out  1         high whenever state != IDLE
// - frame_err out  1         one-cycle strobe: ss_n rose mid-frame
// BEHAVIOUR
// - Reset (async): state=IDLE, miso=0, rx_data=0, rx_valid=0, frame_err=0,
//   rd_addr_seen=0, counter=0, shift regs=0. busy=0.
// - FW = DATA_W+2. En = n-th rising edge after the edge that sees ss_n=0 in IDLE (E0).
// - States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE.
// - IDLE: ss_n=0 -> CHK_CMD at E0.
// - CHK_CMD (E1): load counter=FW; mosi=0 -> WRITE; mosi=1 & !rd_addr_seen ->
//   READ_ADD; mosi=1 & rd_addr_seen -> READ_DATA. mosi X/Z treated as 1.
// - WRITE/READ_ADD/READ_DATA: E2..E(FW+1) shift mosi into bit counter-1
//   (MSB_FIRST) or bit FW-counter (LSB first); counter--.
//   At E(FW+2): rx_data<=shift reg, rx_valid=1 for exactly one cycle.
//   WRITE -> DONE. READ_ADD -> DONE, rd_addr_seen<=1. READ_DATA -> TX_WAIT.
// - TX_WAIT: first edge with tx_valid=1 latches tx_data, counter=DATA_W,
//   -> TX_SHIFT. Waits indefinitely otherwise.
// - TX_SHIFT: DATA_W edges, each drives miso<=next bit (per MSB_FIRST);
//   after last bit rd_addr_seen<=0, -> DONE. miso holds last bit in DONE.
// - DONE: idle until ss_n=1; extra mosi bits ignored.
// - ss_n=1 in any non-IDLE state: -> IDLE next edge, miso<=0, counter<=0.
//   If state in {CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT}:
//   frame_err=1 for one cycle, no rx_valid, rx_data and rd_addr_seen unchanged.
//   ss_n=1 in the same edge the frame completes: completion wins (rx_valid=1,
//   no frame_err), then IDLE.
// - rx_valid and frame_err never high together; rx_valid never 2 cycles in a row.
// - Reset mid-transaction: immediate return to reset values; next frame must
//   start from ss_n falling (ss_n already low after reset -> CHK_CMD at next edge).
// TESTING
// - Write: DATA_W=8, ss_n low, mosi cmd=0 then 10'b00_1010_0101 MSB first ->
//   rx_data=10'h0A5, rx_valid one cycle at E12, state DONE, frame_err=0.
// - Read addr then data: cmd=1,10'h2_3C -> rx_valid, rd_addr_seen=1; new frame
//   cmd=1,10'h3_00 -> rx_valid, TX_WAIT; tx_valid=1 tx_data=8'hA5 ->
//   miso 1,0,1,0,0,1,0,1 over 8 cycles; rd_addr_seen=0 after.
// - Abort: ss_n high after 5 payload bits of write -> frame_err one cycle,
//   rx_valid stays 0, rx_data keeps prior value, next frame decodes normally.
// - Async rst pulse mid-TX_SHIFT (between clk edges) -> miso=0, busy=0,
//   rd_addr_seen=0 immediately; next read frame goes READ_ADD.
// - DATA_W=16, MSB_FIRST=0: write 18'h2_1234 LSB first -> rx_data=18'h2_1234;
//   tx_data=16'h8001 -> miso 1,0x14,1.
// - Boundary: ss_n rises on completing edge E(FW+2) -> rx_valid=1, frame_err=0.

Source files
------------

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end: frames MOSI into {opcode, payload} words
// and serialises read data onto MISO, with abort detection and busy flag.
//
// state        | meaning
// ST_IDLE      | waiting for ss_n low
// ST_CHK_CMD   | sample command bit, pick write / read-address / read-data path
// ST_WRITE     | shifting a write word
// ST_READ_ADD  | shifting a read-address word
// ST_READ_DATA | shifting the word that precedes a data return
// ST_TX_WAIT   | waiting for tx_valid
// ST_TX_SHIFT  | driving tx bits onto miso
// ST_DONE      | frame complete, ignoring mosi until ss_n high
`timescale 1ns/1ps
module spi_slave_param #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              busy,
    output logic              frame_err
);
    localparam int FW = DATA_W + 2;
    localparam int CW = $clog2(FW + 1);
    localparam logic [CW-1:0] FW_C = CW'(FW);
    localparam logic [CW-1:0] DW_C = CW'(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHK_CMD, ST_WRITE, ST_READ_ADD,
        ST_READ_DATA, ST_TX_WAIT, ST_TX_SHIFT, ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FW-1:0]     rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [FW-1:0]     rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              rd_seen_q, rd_seen_d;
    logic              miso_q, miso_d;
    logic              busy_q, busy_d;
    logic              rx_done;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rd_seen_d   = rd_seen_q;
        miso_d      = miso_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        rx_done     = ((state_q == ST_WRITE) || (state_q == ST_READ_ADD) ||
                       (state_q == ST_READ_DATA)) && (cnt_q == '0);

        // A completing rx edge takes priority over ss_n rising on that edge.
        if ((state_q != ST_IDLE) && ss_n && !rx_done) begin
            state_d     = ST_IDLE;
            miso_d      = 1'b0;
            cnt_d       = '0;
            frame_err_d = (state_q != ST_DONE);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!ss_n) state_d = ST_CHK_CMD;
                end
                ST_CHK_CMD: begin
                    cnt_d      = FW_C;
                    rx_shift_d = '0;
                    if (mosi == 1'b0)   state_d = ST_WRITE;
                    else if (rd_seen_q) state_d = ST_READ_DATA;
                    else                state_d = ST_READ_ADD;
                end
                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    if (cnt_q != '0) begin
                        if (MSB_FIRST) rx_shift_d = {rx_shift_q[FW-2:0], mosi};
                        else           rx_shift_d = {mosi, rx_shift_q[FW-1:1]};
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        if (state_q == ST_READ_DATA) begin
                            state_d = ST_TX_WAIT;
                        end else begin
                            state_d = ST_DONE;
                            if (state_q == ST_READ_ADD) rd_seen_d = 1'b1;
                        end
                        if (ss_n) begin
                            state_d = ST_IDLE;
                            miso_d  = 1'b0;
                            cnt_d   = '0;
                        end
                    end
                end
                ST_TX_WAIT: begin
                    if (tx_valid) begin
                        tx_shift_d = tx_data;
                        cnt_d      = DW_C;
                        state_d    = ST_TX_SHIFT;
                    end
                end
                ST_TX_SHIFT: begin
                    if (MSB_FIRST) begin
                        miso_d     = tx_shift_q[DATA_W-1];
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end else begin
                        miso_d     = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[DATA_W-1:1]};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        rd_seen_d = 1'b0;
                        state_d   = ST_DONE;
                    end
                end
                ST_DONE: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rd_seen_q   <= 1'b0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            rd_seen_q   <= rd_seen_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
        end
    end

    assign miso      = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: an 8-bit MSB-first and a 16-bit LSB-first instance
// driven by frame-level tasks that also predict every output cycle by cycle.
`timescale 1ns/1ps
module tb_spi_slave_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  ss_n, mosi, txv;
    logic [15:0] txd [2];
    logic        miso0, miso1, rxv0, rxv1, busy0, busy1, fe0, fe1;
    logic [9:0]  rxd0;
    logic [17:0] rxd1;

    spi_slave_param #(.DATA_W(8), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .ss_n(ss_n[0]), .mosi(mosi[0]), .miso(miso0),
        .rx_data(rxd0), .rx_valid(rxv0), .tx_data(txd[0][7:0]), .tx_valid(txv[0]),
        .busy(busy0), .frame_err(fe0));

    spi_slave_param #(.DATA_W(16), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .ss_n(ss_n[1]), .mosi(mosi[1]), .miso(miso1),
        .rx_data(rxd1), .rx_valid(rxv1), .tx_data(txd[1]), .tx_valid(txv[1]),
        .busy(busy1), .frame_err(fe1));

    // Expected outputs per instance, plus the read-address-seen flag the
    // protocol implies.
    logic [17:0] e_rxd  [2];
    logic        e_rxv  [2];
    logic        e_fe   [2];
    logic        e_busy [2];
    logic        e_miso [2];
    bit          rd_seen[2];
    int          checks = 0;
    int          passes = 0;
    bit          cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    function automatic logic [17:0] act_rxd(input int d);
        return (d == 0) ? {8'b0, rxd0} : rxd1;
    endfunction
    function automatic logic act_bit(input int d, input int which);
        case (which)
            0: return (d == 0) ? rxv0  : rxv1;
            1: return (d == 0) ? fe0   : fe1;
            2: return (d == 0) ? busy0 : busy1;
            default: return (d == 0) ? miso0 : miso1;
        endcase
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d rx_data", d),   act_rxd(d),    e_rxd[d]);
                check($sformatf("d%0d rx_valid", d),  act_bit(d, 0), e_rxv[d]);
                check($sformatf("d%0d frame_err", d), act_bit(d, 1), e_fe[d]);
                check($sformatf("d%0d busy", d),      act_bit(d, 2), e_busy[d]);
                check($sformatf("d%0d miso", d),      act_bit(d, 3), e_miso[d]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            e_rxv[d] = 1'b0;
            e_fe[d]  = 1'b0;
        end
    endtask

    task automatic end_frame(input int d, input bit err);
        ss_n[d] = 1'b1;
        tick();
        e_busy[d] = 1'b0;
        e_miso[d] = 1'b0;
        e_fe[d]   = err;
    endtask

    // abort_after >= 0: raise ss_n instead of sending payload bit abort_after.
    task automatic frame(input int d, input bit cmd, input logic [17:0] word,
                         input int abort_after, input bit close_on_done);
        int fw;
        bit msb;
        fw  = (d == 0) ? 10 : 18;
        msb = (d == 0);
        ss_n[d] = 1'b0;
        mosi[d] = 1'($urandom);
        tick();
        e_busy[d] = 1'b1;
        mosi[d] = cmd;
        tick();
        for (int i = 0; i < fw; i++) begin
            if (i == abort_after) begin
                end_frame(d, 1'b1);
                return;
            end
            mosi[d] = msb ? word[fw-1-i] : word[i];
            tick();
        end
        mosi[d] = 1'($urandom);
        if (close_on_done) ss_n[d] = 1'b1;
        tick();
        e_rxv[d] = 1'b1;
        e_rxd[d] = word;
        if (cmd && !rd_seen[d]) rd_seen[d] = 1'b1;
        if (close_on_done) begin
            e_busy[d] = 1'b0;
            e_miso[d] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            e_rxd[d] = '0; e_rxv[d] = 1'b0; e_fe[d] = 1'b0;
            e_busy[d] = 1'b0; e_miso[d] = 1'b0; rd_seen[d] = 1'b0;
        end
    endtask

    // reset_after >= 0: pulse rst between edges after that many bits.
    task automatic send_tx(input int d, input logic [15:0] data, input int wait_cyc,
                           input int reset_after, output logic [15:0] got);
        int w;
        bit msb;
        w   = (d == 0) ? 8 : 16;
        msb = (d == 0);
        got = '0;
        repeat (wait_cyc) tick();
        txv[d] = 1'b1;
        txd[d] = data;
        tick();
        txv[d] = 1'b0;
        txd[d] = 16'($urandom);
        for (int k = 0; k < w; k++) begin
            if (k == reset_after) begin
                #2;
                do_reset();
                #1;
                check("reset mid-tx miso", act_bit(d, 3), 1'b0);
                check("reset mid-tx busy", act_bit(d, 2), 1'b0);
                ss_n = 2'b11;
                rst  = 1'b0;
                return;
            end
            tick();
            e_miso[d] = msb ? data[w-1-k] : data[k];
            got[k] = act_bit(d, 3);
        end
        rd_seen[d] = 1'b0;
    endtask

    logic [15:0] got;

    initial begin
        ss_n = 2'b11; mosi = 2'b00; txv = 2'b00;
        txd[0] = '0; txd[1] = '0;
        #1;
        do_reset();
        #1;
        cmp_en = 1'b1;
        #20;
        check("reset rx_data0", {22'b0, rxd0}, 32'h0);
        check("reset busy0", busy0, 1'b0);
        check("reset miso0", miso0, 1'b0);
        rst = 1'b0;

        // Write 10'h0A5, MSB first.
        frame(0, 1'b0, 18'h000A5, -1, 1'b0);
        check("write rx_data", {22'b0, rxd0}, 32'h0A5);
        check("write rx_valid", rxv0, 1'b1);
        end_frame(0, 1'b0);
        tick();

        // Read address then read data with an 8'hA5 return.
        frame(0, 1'b1, 18'h0023C, -1, 1'b0);
        end_frame(0, 1'b0);
        frame(0, 1'b1, 18'h00300, -1, 1'b0);
        send_tx(0, 16'h00A5, 3, -1, got);
        check("tx A5 bit sequence", {24'b0, got[7:0]}, 32'hA5);
        end_frame(0, 1'b0);

        // Abort a write after 5 payload bits; rx_data keeps 10'h300.
        frame(0, 1'b0, 18'h00155, 5, 1'b0);
        check("abort frame_err", fe0, 1'b1);
        check("abort keeps rx_data", {22'b0, rxd0}, 32'h300);
        frame(0, 1'b0, 18'h003C7, -1, 1'b0);
        end_frame(0, 1'b0);

        // ss_n rises on the completing edge.
        frame(0, 1'b0, 18'h001C3, -1, 1'b1);
        check("boundary rx_valid", rxv0, 1'b1);
        check("boundary frame_err", fe0, 1'b0);
        tick();

        // Abort in TX_WAIT leaves the address flag set; then reset mid-shift.
        frame(0, 1'b1, 18'h00011, -1, 1'b0);
        end_frame(0, 1'b0);
        frame(0, 1'b1, 18'h00022, -1, 1'b0);
        tick(); tick();
        end_frame(0, 1'b1);
        frame(0, 1'b1, 18'h00033, -1, 1'b0);
        send_tx(0, 16'h003C, 1, 3, got);
        tick();
        frame(0, 1'b1, 18'h00044, -1, 1'b0);
        txv[0] = 1'b1; txd[0] = 16'h00FF;
        tick(); tick();
        txv[0] = 1'b0;
        end_frame(0, 1'b0);
        check("post-reset read is address", fe0, 1'b0);
        tick();

        // 16-bit LSB-first instance.
        frame(1, 1'b0, 18'h21234, -1, 1'b0);
        check("w16 rx_data", {14'b0, rxd1}, 32'h21234);
        end_frame(1, 1'b0);
        frame(1, 1'b1, 18'h00001, -1, 1'b0);
        end_frame(1, 1'b0);
        frame(1, 1'b1, 18'h3ABCD, -1, 1'b0);
        send_tx(1, 16'h8001, 0, -1, got);
        check("tx 8001 bit sequence", {16'b0, got}, 32'h8001);
        end_frame(1, 1'b0);
        tick(); tick();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
